// File: rtl/tone_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_seq_pkg
//  Description : Shared definitions for the tone sequencer: FSM state
//                encoding, tone-code constants, the melody ROM table and
//                small helpers for button decoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tone_seq_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Tone codes: 1..6 are audible, half-period = code * HALF_BASE
    localparam logic [2:0] TONE_REST = 3'd0;
    localparam logic [2:0] TONE_END  = 3'd7;

    // Melody rows packed as {step7, step6, ..., step0}
    localparam logic [23:0] MEL0_ROW = {3'd1, 3'd6, 3'd5, 3'd4, 3'd0, 3'd3, 3'd2, 3'd1};
    localparam logic [23:0] MEL1_ROW = {3'd1, 3'd1, 3'd1, 3'd1, 3'd7, 3'd3, 3'd0, 3'd2};
    localparam logic [23:0] MEL2_ROW = {3'd7, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    localparam logic [23:0] MEL3_ROW = {3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd0, 3'd3, 3'd3};

    // 4 melodies x 8 steps x 3-bit tone code
    function automatic logic [2:0] melody_rom(input logic [1:0] mel, input logic [2:0] step);
        logic [23:0] row;
        logic [23:0] sh;
        case (mel)
            2'd0:    row = MEL0_ROW;
            2'd1:    row = MEL1_ROW;
            2'd2:    row = MEL2_ROW;
            default: row = MEL3_ROW;
        endcase
        sh = row >> (5'(step) * 5'd3);
        return sh[2:0];
    endfunction

    // Lowest-index melody among simultaneous presses
    function automatic logic [1:0] lowest_melody(input logic [3:0] p);
        if (p[0])      return 2'd0;
        else if (p[1]) return 2'd1;
        else if (p[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] mel_onehot(input logic [1:0] mel);
        return 4'b0001 << mel;
    endfunction

endpackage : tone_seq_pkg
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tone_gen
//  Description : Reusable square-wave divider. While enabled, the wave starts
//                low and toggles every half_period clocks. Dropping enable
//                clears both the divider and the wave on the next edge.
//  Revision    : 1.0 - initial release
//  Ports       : clk         - system clock
//                rst_n       - asynchronous active-low reset
//                enable      - run the divider (low = clear)
//                half_period - clocks per half-period, must be non-zero
//                wave        - square-wave output
// ============================================================================
module tone_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [W-1:0] half_period,
    output logic         wave
);

    logic [W-1:0] cnt_q;
    logic         wave_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else if (!enable) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else if (cnt_q == half_period - W'(1)) begin
            cnt_q  <= '0;
            wave_q <= ~wave_q;
        end else begin
            cnt_q  <= cnt_q + W'(1);
        end
    end

    assign wave = wave_q;

endmodule : tone_gen
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_sequencer
//  Description : Push-button melody player. Five active-low keys are
//                synchronised and edge-detected; key[0..3] start melodies
//                0..3, key[4] stops. Each melody step sounds for STEP_TICKS
//                clocks followed by GAP_TICKS of silence.
//  Revision    : 1.0 - initial release
//  Ports       : clk   - system clock
//                rst_n - asynchronous active-low reset
//                key   - [4:0] push buttons, 0 = pressed
//                beep  - square wave to the buzzer
//                led   - [3:0] one-hot playing melody, [4] busy
//  Options     : TONE_SEQ_LOOP_EN - when defined, melodies repeat from
//                step 0 instead of returning to idle at their end.
// ============================================================================
module tone_sequencer #(
    parameter int HALF_BASE  = 100_000,
    parameter int STEP_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 1_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key,
    output logic       beep,
    output logic [4:0] led
);

    import tone_seq_pkg::*;

    localparam int CNT_MAX = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HP_W    = $clog2(6 * HALF_BASE + 1);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    // ------------------------------------------------------------------
    // Key synchronizer and falling-edge detector (reset to "released")
    // ------------------------------------------------------------------
    logic [4:0] key_meta_q;
    logic [4:0] key_sync_q;
    logic [4:0] key_prev_q;
    logic [4:0] press;
    logic       stop_press;
    logic       mel_press;
    logic       any_press;
    logic [1:0] mel_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            key_prev_q <= '1;
        end else begin
            key_meta_q <= key;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    assign press      = key_prev_q & ~key_sync_q;
    assign stop_press = press[4];
    assign mel_press  = |press[3:0];
    assign any_press  = |press;
    assign mel_sel    = lowest_melody(press[3:0]);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       melody_q, melody_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] tone_code;
    logic [2:0] next_step;
    logic [2:0] next_code;
    logic       seq_end;

    assign tone_code = melody_rom(melody_q, step_q);
    assign next_step = step_q + 3'd1;
    assign next_code = melody_rom(melody_q, next_step);
    // The melody ends after the last ROM slot or just before an end marker
    assign seq_end   = (step_q == 3'd7) || (next_code == TONE_END);

    always_comb begin
        state_d  = state_q;
        melody_d = melody_q;
        step_d   = step_q;
        cnt_d    = cnt_q;

        if (stop_press) begin
            state_d = ST_IDLE;
            step_d  = 3'd0;
            cnt_d   = '0;
        end else if (mel_press) begin
            // A new melody preempts whatever is happening
            state_d  = ST_LOAD;
            melody_d = mel_sel;
            step_d   = 3'd0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    step_d = 3'd0;
                    cnt_d  = '0;
                end
                ST_LOAD: begin
                    step_d = 3'd0;
                    cnt_d  = '0;
                    // A melody whose first slot is the end marker has nothing to play
                    state_d = (tone_code == TONE_END) ? ST_IDLE : ST_PLAY;
                end
                ST_PLAY: begin
                    if (cnt_q == STEP_LAST) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (seq_end) begin
                            step_d = 3'd0;
`ifdef TONE_SEQ_LOOP_EN
                            state_d = ST_PLAY;
`else
                            state_d = ST_IDLE;
`endif
                        end else begin
                            step_d  = next_step;
                            state_d = ST_PLAY;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    step_d  = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            melody_q <= 2'd0;
            step_q   <= 3'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            melody_q <= melody_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Tone generation: divider only runs on audible PLAY steps, and any
    // press clears it so a preempted tone never leaks into the next one.
    // ------------------------------------------------------------------
    logic            tone_en;
    logic [HP_W-1:0] half_period;
    logic            wave;

    assign tone_en     = (state_q == ST_PLAY) && (tone_code != TONE_REST) &&
                         (tone_code != TONE_END) && !any_press;
    assign half_period = HP_W'(tone_code) * HP_W'(HALF_BASE);

    tone_gen #(
        .W (HP_W)
    ) u_tone_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (tone_en),
        .half_period (half_period),
        .wave        (wave)
    );

    // Gating by state makes beep drop immediately on reset or leaving PLAY
    assign beep = wave && (state_q == ST_PLAY) && !any_press;
    assign led  = (state_q == ST_IDLE) ? 5'b00000 : {1'b1, mel_onehot(melody_q)};

endmodule : tone_sequencer
`default_nettype wire

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter HALF_BASE, default 100_000, meaning clk cycles per beep half-period for tone code 1.
REQ-002 SHALL have parameter STEP_TICKS, default 12_500_000, meaning clk cycles a note sounds.
REQ-003 SHALL have parameter GAP_TICKS, default 1_250_000, meaning silent clk cycles after each note.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have port key, input, 5, push buttons, active-low (0 = pressed).
REQ-007 SHALL have port beep, output, 1, square wave to the buzzer.
REQ-008 SHALL have port led, output, 5: led[3:0] one-hot playing melody, led[4] busy.

Function
REQ-009 SHALL pass key through a 2-flop synchronizer, then detect a press as a high-to-low edge of the synchronized value, giving a 1-cycle press pulse per button.
REQ-010 SHALL map presses on key[0]..key[3] to melodies 0..3 and a press on key[4] to stop.
REQ-011 SHALL resolve simultaneous presses: stop wins; otherwise the lowest melody index wins.
REQ-012 SHALL implement FSM states IDLE, LOAD, PLAY, GAP.
REQ-013 SHALL move IDLE->LOAD on a melody press; LOAD latches the melody index, sets step=0 and moves to PLAY on the next cycle.
REQ-014 SHALL treat the time from a press pulse to LOAD as 1 cycle, making key-low-to-LOAD 3 cycles.
REQ-015 SHALL hold PLAY exactly STEP_TICKS cycles, then GAP exactly GAP_TICKS cycles with beep=0, then advance step.
REQ-016 SHALL use the melody ROM layout of 4 melodies x 8 steps x 3-bit tone code: 0 = rest, 1..6 = tone with half-period code*HALF_BASE, 7 = end marker.
REQ-017 SHALL go to IDLE after GAP when the next step is 8 or when the code read at step entry is 7; an end-marker step produces no PLAY time.
REQ-018 SHALL keep beep at 0 and hold the divider at 0 during a rest step.
REQ-019 SHALL, during a tone step, have beep start at 0 on PLAY entry and toggle every code*HALF_BASE cycles; the first toggle comes code*HALF_BASE cycles after entry.
REQ-020 SHALL make a melody press during LOAD/PLAY/GAP preempt: next state LOAD, beep forced to 0 and divider cleared in that cycle.
REQ-021 SHALL make a stop press in any state go to IDLE next cycle, with beep=0 from that cycle on.
REQ-022 SHALL keep beep=0, led=5'b00000 in IDLE; otherwise led[4]=1 and led[3:0]=1<<melody.
REQ-023 SHALL size all counters to hold 6*HALF_BASE, STEP_TICKS and GAP_TICKS without overflow; counters never wrap mid-step.

Reset
REQ-024 SHALL, while rst_n=0, force FSM=IDLE, beep=0, led=0, step=0, all counters and synchronizer flops to 1 (released key), with no press pulse on release.
REQ-025 SHALL abandon any melody on reset mid-operation; no state survives.

Configuration
REQ-026 SHALL, with macro TONE_SEQ_LOOP_EN defined, wrap from step 8 or the end marker to step 0 of the same melody (GAP->PLAY) until stop or preempt.
REQ-027 SHALL, without TONE_SEQ_LOOP_EN, behave per REQ-017.

Structure
REQ-028 SHALL place the FSM state enum, tone-code constants (REST=0, END=7) and the melody ROM table function in package tone_seq_pkg.
REQ-029 SHALL implement the square-wave divider as sub-module tone_gen (inputs enable, half_period; output wave) so it can be reused.

Verification (HALF_BASE=4, STEP_TICKS=64, GAP_TICKS=8)
REQ-030 SHALL cover: key[0] low at cycle 10 -> LOAD at cycle 13, PLAY at 14, beep toggles every 4*code cycles for 64 cycles, led=5'b10001.
REQ-031 SHALL cover: melody with code 7 at step 3 -> IDLE after step 2's GAP, beep=0, led=0.
REQ-032 SHALL cover: key[1] and key[3] pressed the same cycle -> melody 1 plays, led=5'b10010.
REQ-033 SHALL cover: key[4] pressed mid-PLAY -> IDLE next cycle, beep=0; key[2] pressed mid-PLAY of melody 0 -> LOAD next cycle, led=5'b10100.
REQ-034 SHALL cover: rst_n pulled low mid-GAP -> beep=0, led=0 immediately (asynchronous); no spurious play after release.
REQ-035 SHALL cover: with TONE_SEQ_LOOP_EN, melody 0 runs 3 full passes with step wrap 7->0, and no IDLE until key[4].
